// File: rtl/digital_pll_pkg.sv
// rtl/digital_pll_pkg.sv - lock-state encoding and divider width for the PLL lock detector
package digital_pll_pkg;

    localparam int DIV_W = 5;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2,
        ST_SLIP     = 2'd3
    } lock_state_e;

endpackage

// File: rtl/digital_pll_osc_sync.sv
// rtl/digital_pll_osc_sync.sv - osc synchronizer with rising-edge pulse in the PLL clock domain
module digital_pll_osc_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic resetb,
    input  logic osc,
    output logic osc_rise
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic [SYNC_STAGES:0]   warm_q, warm_d;

    // warm_q masks edges until prev_q holds a real osc sample, so a high osc at reset release is not an edge
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], osc};
        prev_d   = sync_q[SYNC_STAGES-1];
        warm_d   = {warm_q[SYNC_STAGES-1:0], 1'b1};
        osc_rise = warm_q[SYNC_STAGES] & sync_q[SYNC_STAGES-1] & ~prev_q;
    end

    always_ff @(posedge clock) begin
        if (!resetb) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            warm_q <= '0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            warm_q <= warm_d;
        end
    end

endmodule

// File: rtl/digital_pll_lock_detect.sv
// rtl/digital_pll_lock_detect.sv - PLL frequency lock detector measuring PLL cycles per osc period
// Optional lock-loss interrupt (irq / irq_clear) enabled by PLL_LOCK_LOSS_IRQ_EN.
module digital_pll_lock_detect
    import digital_pll_pkg::*;
#(
    parameter int CNT_W        = 8,
    parameter int TOL          = 1,
    parameter int LOCK_COUNT   = 8,
    parameter int UNLOCK_COUNT = 2,
    parameter int SYNC_STAGES  = 2
) (
    input  logic             clock,
    input  logic             resetb,
    input  logic             enable,
    input  logic             osc,
    input  logic [DIV_W-1:0] div,
    output logic             locked,
    output logic [1:0]       lock_state,
    output logic [CNT_W-1:0] period_count,
    output logic             count_valid
`ifdef PLL_LOCK_LOSS_IRQ_EN
    ,
    input  logic             irq_clear,
    output logic             irq
`endif
);

    localparam int GC_W = $clog2(LOCK_COUNT + 1);
    localparam int BC_W = $clog2(UNLOCK_COUNT + 1);
    localparam logic [CNT_W-1:0]      CNT_MAX   = '1;
    localparam logic [GC_W-1:0]       GOOD_LAST = GC_W'(LOCK_COUNT - 1);
    localparam logic [BC_W-1:0]       BAD_LAST  = BC_W'(UNLOCK_COUNT - 1);
    localparam logic signed [CNT_W:0] TOL_S     = (CNT_W + 1)'(TOL);

    logic                osc_rise;
    logic [CNT_W-1:0]    counter_q, counter_d;
    logic [CNT_W-1:0]    period_q, period_d;
    logic                run_q, run_d;
    logic                skip_q, skip_d;
    logic                valid_q, valid_d;
    logic                locked_q, locked_d;
    lock_state_e         state_q, state_d;
    logic [GC_W-1:0]     good_cnt_q, good_cnt_d;
    logic [BC_W-1:0]     bad_cnt_q, bad_cnt_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic                meas_en;
    logic                good;
    logic signed [CNT_W:0] diff;

    digital_pll_osc_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_osc_sync (
        .clock    (clock),
        .resetb   (resetb),
        .osc      (osc),
        .osc_rise (osc_rise)
    );

    assign diff = $signed({1'b0, counter_q}) - $signed({{(CNT_W - DIV_W + 1){1'b0}}, div_q});
    assign good = (div_q != '0) && (diff <= TOL_S) && (diff >= -TOL_S);

    // run_q: counter is timing a period; skip_q: after a timeout the next edge only restarts timing
    always_comb begin
        counter_d  = counter_q;
        period_d   = period_q;
        run_d      = run_q;
        skip_d     = skip_q;
        valid_d    = 1'b0;
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        div_d      = div;
        meas_en    = 1'b0;
        if (!enable) begin
            counter_d  = '0;
            period_d   = '0;
            run_d      = 1'b0;
            skip_d     = 1'b0;
            state_d    = ST_UNLOCKED;
            good_cnt_d = '0;
            bad_cnt_d  = '0;
        end else if (div != div_q) begin
            counter_d  = '0;
            run_d      = 1'b0;
            skip_d     = 1'b0;
            state_d    = ST_UNLOCKED;
            good_cnt_d = '0;
            bad_cnt_d  = '0;
        end else begin
            if (osc_rise) begin
                counter_d = CNT_W'(1);
                run_d     = 1'b1;
                skip_d    = 1'b0;
                meas_en   = run_q & ~skip_q;
            end else if (run_q) begin
                if (counter_q == CNT_MAX) begin
                    counter_d = '0;
                    skip_d    = 1'b1;
                    meas_en   = 1'b1;
                end else begin
                    counter_d = counter_q + CNT_W'(1);
                end
            end
            if (meas_en) begin
                period_d = counter_q;
                valid_d  = 1'b1;
                case (state_q)
                    ST_UNLOCKED: if (good) begin
                        good_cnt_d = GC_W'(1);
                        state_d    = (LOCK_COUNT == 1) ? ST_LOCKED : ST_ACQUIRE;
                    end
                    ST_ACQUIRE: if (good) begin
                        good_cnt_d = good_cnt_q + GC_W'(1);
                        if (good_cnt_q == GOOD_LAST) state_d = ST_LOCKED;
                    end else begin
                        good_cnt_d = '0;
                        state_d    = ST_UNLOCKED;
                    end
                    ST_LOCKED: if (!good) begin
                        bad_cnt_d = BC_W'(1);
                        state_d   = (UNLOCK_COUNT == 1) ? ST_UNLOCKED : ST_SLIP;
                    end
                    ST_SLIP: if (good) begin
                        bad_cnt_d = '0;
                        state_d   = ST_LOCKED;
                    end else begin
                        bad_cnt_d = bad_cnt_q + BC_W'(1);
                        if (bad_cnt_q == BAD_LAST) state_d = ST_UNLOCKED;
                    end
                    default: state_d = ST_UNLOCKED;
                endcase
            end
        end
        locked_d = (state_d == ST_LOCKED) || (state_d == ST_SLIP);
    end

    always_ff @(posedge clock) begin
        if (!resetb) begin
            counter_q  <= '0;
            period_q   <= '0;
            run_q      <= 1'b0;
            skip_q     <= 1'b0;
            valid_q    <= 1'b0;
            locked_q   <= 1'b0;
            state_q    <= ST_UNLOCKED;
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
            div_q      <= '0;
        end else begin
            counter_q  <= counter_d;
            period_q   <= period_d;
            run_q      <= run_d;
            skip_q     <= skip_d;
            valid_q    <= valid_d;
            locked_q   <= locked_d;
            state_q    <= state_d;
            good_cnt_q <= good_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
            div_q      <= div_d;
        end
    end

    assign locked       = locked_q;
    assign lock_state   = state_q;
    assign period_count = period_q;
    assign count_valid  = valid_q;

`ifdef PLL_LOCK_LOSS_IRQ_EN
    logic irq_q, irq_d;

    // lock loss only counts while enabled; a disable-driven clear is not an event
    always_comb begin
        irq_d = irq_q;
        if (irq_clear) irq_d = 1'b0;
        if (enable && locked_q && (state_d == ST_UNLOCKED)) irq_d = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!resetb) irq_q <= 1'b0;
        else         irq_q <= irq_d;
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_digital_pll_lock_detect.sv
// tb/tb_digital_pll_lock_detect.sv - scoreboard bench for digital_pll_lock_detect with timestamp-based reference model
module tb_digital_pll_lock_detect;

    localparam int LC   = 8;
    localparam int UC   = 2;
    localparam int MAXC = 255;

    logic       clock  = 1'b0;
    logic       resetb = 1'b0;
    logic       enable = 1'b1;
    logic       osc    = 1'b0;
    logic [4:0] div    = 5'd8;
    logic       locked;
    logic [1:0] lock_state;
    logic [7:0] period_count;
    logic       count_valid;
`ifdef PLL_LOCK_LOSS_IRQ_EN
    logic       irq_clear = 1'b0;
    logic       irq;
`endif

    digital_pll_lock_detect dut (
        .clock        (clock),
        .resetb       (resetb),
        .enable       (enable),
        .osc          (osc),
        .div          (div),
        .locked       (locked),
        .lock_state   (lock_state),
        .period_count (period_count),
        .count_valid  (count_valid)
`ifdef PLL_LOCK_LOSS_IRQ_EN
        ,
        .irq_clear    (irq_clear),
        .irq          (irq)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cv_seen = 0;

    typedef struct {
        int p;
        int st;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    // model state: times are driver cycle numbers; anchor is the cycle the DUT counter reads zero
    int cyc = 0;
    bit osc_prev = 1'b0;
    bit m_run = 1'b0;
    bit m_skip = 1'b0;
    int m_anchor = 0;
    int m_good_run = 0;
    int m_bad_run = 0;
    bit m_locked = 1'b0;
    bit m_irq = 1'b0;
    int m_div = 8;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int m_state();
        if (m_locked) return (m_bad_run > 0) ? 3 : 2;
        return (m_good_run > 0) ? 1 : 0;
    endfunction

    task automatic model_meas(input int p);
        bit good;
        good = (m_div != 0) && (p - m_div <= 1) && (m_div - p <= 1);
        if (!m_locked) begin
            if (good) begin
                m_good_run++;
                if (m_good_run >= LC) begin
                    m_locked  = 1'b1;
                    m_bad_run = 0;
                end
            end else begin
                m_good_run = 0;
            end
        end else if (good) begin
            m_bad_run = 0;
        end else begin
            m_bad_run++;
            if (m_bad_run >= UC) begin
                m_locked   = 1'b0;
                m_good_run = 0;
                m_bad_run  = 0;
                m_irq      = 1'b1;
            end
        end
        exp_q.push_back('{p, m_state()});
    endtask

    task automatic model_clear(input bit lock_loss_event);
        if (lock_loss_event && m_locked) m_irq = 1'b1;
        m_run      = 1'b0;
        m_skip     = 1'b0;
        m_locked   = 1'b0;
        m_good_run = 0;
        m_bad_run  = 0;
    endtask

    task automatic tick(input bit o);
        @(posedge clock);
        #1;
        osc = o;
        cyc++;
        if (o && !osc_prev) begin
            if (m_run && !m_skip) model_meas(cyc - m_anchor);
            m_run    = 1'b1;
            m_skip   = 1'b0;
            m_anchor = cyc;
        end else if (m_run && (cyc - m_anchor == MAXC)) begin
            model_meas(MAXC);
            m_skip   = 1'b1;
            m_anchor = cyc + 1;
        end
        osc_prev = o;
    endtask

    task automatic period(input int p);
        for (int i = 0; i < p / 2; i++) tick(1'b1);
        for (int i = 0; i < p - p / 2; i++) tick(1'b0);
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) tick(1'b0);
    endtask

    task automatic sync_check(input string tag);
        check({tag, " lock_state"}, lock_state, m_state());
        check({tag, " locked"}, locked, m_locked);
`ifdef PLL_LOCK_LOSS_IRQ_EN
        check({tag, " irq"}, irq, m_irq);
`endif
    endtask

    task automatic pulse_irq_clear();
`ifdef PLL_LOCK_LOSS_IRQ_EN
        irq_clear = 1'b1;
        tick(1'b0);
        irq_clear = 1'b0;
        m_irq     = 1'b0;
        tick(1'b0);
        check("irq after clear", irq, 0);
`endif
    endtask

    always @(negedge clock) begin
        if (resetb && count_valid) begin
            cv_seen++;
            check("pending expectation", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("period_count", period_count, mon_e.p);
                check("lock_state", lock_state, mon_e.st);
                check("locked", locked, int'(mon_e.st >= 2));
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        // reset with osc toggling
        resetb = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock);
            #1;
            osc = ~osc;
        end
        check("reset locked", locked, 0);
        check("reset lock_state", lock_state, 0);
        check("reset period_count", period_count, 0);
        check("reset count_valid", count_valid, 0);
        osc      = 1'b0;
        osc_prev = 1'b0;
        @(posedge clock);
        #1;
        resetb = 1'b1;
        model_clear(1'b0);
        quiet(6);

        // first edge only starts the counter
        period(8);
        check("no count_valid after first edge", cv_seen, 0);

        // eight good periods of 8 lock the detector
        for (int i = 0; i < 8; i++) period(8);
        sync_check("after 8 good");
        check("locked after 8 good", locked, 1);

        // tolerance edges and a single slip
        period(9);
        period(7);
        period(10);
        period(8);
        period(8);
        sync_check("after slip recovery");

        // two bad periods drop lock
        period(11);
        period(11);
        period(8);
        sync_check("after two bad");
        check("unlocked after two bad", locked, 0);
        pulse_irq_clear();

        // relock, then osc stuck low: two timeouts
        for (int i = 0; i < 10; i++) period(8);
        sync_check("relocked");
        for (int i = 0; i < 4; i++) tick(1'b1);
        quiet(600);
        sync_check("after timeouts");
        pulse_irq_clear();
        period(255);
        period(256);
        period(8);

        // reach ACQUIRE with five goods then disable for one cycle
        for (int k = 0; k < 20 && !(m_state() == 1 && m_good_run == 5); k++) period(8);
        sync_check("acquire 5");
        quiet(6);
        enable = 1'b0;
        model_clear(1'b0);
        tick(1'b0);
        enable = 1'b1;
        check("disable lock_state", lock_state, 0);
        check("disable locked", locked, 0);
        check("disable period_count", period_count, 0);
        check("disable count_valid", count_valid, 0);

        // relock, then change div
        quiet(4);
        for (int i = 0; i < 10; i++) period(8);
        sync_check("relock before div change");
        quiet(6);
        div   = 5'd4;
        m_div = 4;
        model_clear(1'b1);
        tick(1'b0);
        sync_check("div change");
        pulse_irq_clear();

        // div=0 never locks
        quiet(6);
        div   = 5'd0;
        m_div = 0;
        model_clear(1'b1);
        for (int i = 0; i < 40; i++) period(2 + int'($urandom_range(0, 1)));
        for (int i = 0; i < 4; i++) period(8);
        sync_check("div zero");

        // randomized periods around div=8 with long gaps and occasional disables
        quiet(6);
        div   = 5'd8;
        m_div = 8;
        model_clear(1'b1);
        for (int i = 0; i < 150; i++) begin
            int r;
            r = int'($urandom_range(0, 19));
            if (r == 0) begin
                tick(1'b1);
                tick(1'b1);
                quiet(int'($urandom_range(250, 520)));
            end else if (r == 1) begin
                period(8);
                quiet(6);
                enable = 1'b0;
                model_clear(1'b0);
                tick(1'b0);
                enable = 1'b1;
            end else if (r < 14) begin
                period(int'($urandom_range(7, 9)));
            end else begin
                period(int'($urandom_range(4, 12)));
            end
        end
        period(8);
        period(8);
        sync_check("random end");

        quiet(10);
        check("scoreboard drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
